// File: rtl/brus16_pkg.sv
// Shared definitions for the rectangle-table copy path.
// Provides the bus width constants, the default rectangle table geometry,
// the copy controller state type and a helper for the total word count.
package brus16_pkg;

    localparam int          BRUS_ADDR_WIDTH = 16;
    localparam int          BRUS_DATA_WIDTH = 16;
    localparam int          DEF_RECT_COUNT  = 64;
    localparam int          DEF_RECT_WORDS  = 5;
    localparam logic [15:0] DEF_RECT_BASE   = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rect_copy_state_t;

    function automatic int rect_total(input int count, input int words);
        return count * words;
    endfunction

endpackage

// File: rtl/copy_addr_counter.sv
// Loadable up-counter with terminal-count flag, used as the read index of
// the rectangle copy.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   load         clear the count to zero (wins over inc)
//   inc          advance the count by one
//   count        current count
//   tc           high while count equals LAST
module copy_addr_counter
    import brus16_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int LAST  = 319
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == WIDTH'(LAST));

endmodule

// File: rtl/rect_copy_controller.sv
// Copies the rectangle table from CPU data memory into the GPU rectangle
// buffer during the copy window, one word per cycle.
//
// state | meaning
// IDLE  | waiting for copy_start
// READ  | issuing reads RECT_BASE+k, writing word k-1
// DRAIN | final write of word TOTAL-1, no read
// DONE  | one-cycle done pulse
//
// Ports:
//   clk, reset            clock and asynchronous active-low reset
//   copy_start, copy      start pulse and copy window flag
//   mem_re/addr/rdata     data-memory read port (rdata one cycle after addr)
//   gpu_we/addr/wdata     GPU rect-buffer write port
//   busy, done, overrun   status: in progress, normal completion, sticky error
module rect_copy_controller
    import brus16_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = BRUS_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = BRUS_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RECT_BASE      = ADDR_WIDTH'(DEF_RECT_BASE),
    parameter int                    RECT_COUNT     = DEF_RECT_COUNT,
    parameter int                    RECT_WORDS     = DEF_RECT_WORDS,
    parameter int                    GPU_ADDR_WIDTH = 9
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      copy_start,
    input  logic                      copy,
    output logic                      mem_re,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      gpu_we,
    output logic [GPU_ADDR_WIDTH-1:0] gpu_addr,
    output logic [DATA_WIDTH-1:0]     gpu_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int TOTAL = rect_total(RECT_COUNT, RECT_WORDS);
    localparam int CW    = GPU_ADDR_WIDTH + 1;

    rect_copy_state_t          state_q, state_d;
    logic                      mem_re_q, mem_re_d;
    logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
    logic                      gpu_we_q, gpu_we_d;
    logic [GPU_ADDR_WIDTH-1:0] gpu_addr_q, gpu_addr_d;
    logic                      overrun_q, overrun_d;

    logic          cnt_load;
    logic          cnt_inc;
    logic [CW-1:0] rd_idx;
    logic          rd_tc;

    copy_addr_counter #(
        .WIDTH (CW),
        .LAST  (TOTAL - 1)
    ) u_rd_idx (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .count (rd_idx),
        .tc    (rd_tc)
    );

    always_comb begin
        state_d    = state_q;
        mem_re_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        gpu_we_d   = 1'b0;
        gpu_addr_d = gpu_addr_q;
        overrun_d  = overrun_q;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (copy_start) begin
                    state_d    = READ;
                    cnt_load   = 1'b1;
                    overrun_d  = 1'b0;
                    mem_re_d   = 1'b1;
                    mem_addr_d = RECT_BASE;
                end
            end
            READ: begin
                if (!copy) begin
                    // Copy window closed early: abandon the rest of the table.
                    state_d   = IDLE;
                    overrun_d = 1'b1;
                end else begin
                    if (copy_start) begin
                        overrun_d = 1'b1;
                    end
                    // The word read this cycle is written next cycle at index k.
                    gpu_we_d   = 1'b1;
                    gpu_addr_d = GPU_ADDR_WIDTH'(rd_idx);
                    if (rd_tc) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_inc    = 1'b1;
                        mem_re_d   = 1'b1;
                        // Wraps modulo 2**ADDR_WIDTH by truncation.
                        mem_addr_d = RECT_BASE + ADDR_WIDTH'(rd_idx + CW'(1));
                    end
                end
            end
            DRAIN: begin
                if (!copy) begin
                    state_d   = IDLE;
                    overrun_d = 1'b1;
                end else begin
                    if (copy_start) begin
                        overrun_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_re_q   <= 1'b0;
            mem_addr_q <= RECT_BASE;
            gpu_we_q   <= 1'b0;
            gpu_addr_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_re_q   <= mem_re_d;
            mem_addr_q <= mem_addr_d;
            gpu_we_q   <= gpu_we_d;
            gpu_addr_q <= gpu_addr_d;
            overrun_q  <= overrun_d;
        end
    end

    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign gpu_we    = gpu_we_q;
    assign gpu_addr  = gpu_addr_q;
    // Read data arrives in the write cycle, so it goes straight to the GPU port.
    assign gpu_wdata = gpu_we_q ? mem_rdata : '0;
    assign busy      = (state_q == READ) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_rect_copy_controller.sv
// Bench for rect_copy_controller: default geometry instance plus a small
// wrapping-address variant. Expected reads and writes are queued when a copy
// is started and consumed as the DUT issues them.
module tb_rect_copy_controller;

    localparam int TOTAL1 = 320;
    localparam int TOTAL2 = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs1, cp1, re1, we1, bz1, dn1, ov1;
    logic [15:0] ad1, rd1, wd1;
    logic [8:0]  ga1;
    logic        cs2, cp2, re2, we2, bz2, dn2, ov2;
    logic [15:0] ad2, rd2, wd2;
    logic [8:0]  ga2;

    always #5 clk = ~clk;

    rect_copy_controller dut1 (
        .clk(clk), .reset(rst_n), .copy_start(cs1), .copy(cp1),
        .mem_re(re1), .mem_addr(ad1), .mem_rdata(rd1),
        .gpu_we(we1), .gpu_addr(ga1), .gpu_wdata(wd1),
        .busy(bz1), .done(dn1), .overrun(ov1)
    );

    rect_copy_controller #(
        .RECT_COUNT(2), .RECT_WORDS(6), .RECT_BASE(16'hFFFE)
    ) dut2 (
        .clk(clk), .reset(rst_n), .copy_start(cs2), .copy(cp2),
        .mem_re(re2), .mem_addr(ad2), .mem_rdata(rd2),
        .gpu_we(we2), .gpu_addr(ga2), .gpu_wdata(wd2),
        .busy(bz2), .done(dn2), .overrun(ov2)
    );

    // Data memory preloaded with word[i] = A000 + i, one-cycle read latency.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    initial begin
        rd1 = '0;
        rd2 = '0;
    end
    always @(posedge clk) begin
        if (re1) rd1 <= mem_word(ad1);
        if (re2) rd2 <= mem_word(ad2);
    end

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        int   off;
        logic mem_re;
        logic gpu_we;
        logic busy;
        logic done;
    } tvec_t;

    wr_t         wq1[$], wq2[$];
    logic [15:0] rq1[$], rq2[$];
    tvec_t       tbl[7];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int wr1_cnt, dn1_cnt, dn1_cyc, last1;
    int wr2_cnt, dn2_cnt, dn2_cyc, last2;
    bit tbl_on = 1'b0;
    int tbl_t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got activity expected none (cycle %0d)", name, cyc);
    endtask

    task automatic sample();
        logic [15:0] a;
        wr_t w;
        if (re1) begin
            if (rq1.size() == 0) bad("rd1_unexpected");
            else begin a = rq1.pop_front(); chk("rd1_addr", 32'(ad1), 32'(a)); end
        end
        if (we1) begin
            if (wq1.size() == 0) bad("wr1_unexpected");
            else begin
                w = wq1.pop_front();
                chk("wr1_addr", 32'(ga1), 32'(w.addr));
                chk("wr1_data", 32'(wd1), 32'(w.data));
            end
            wr1_cnt++;
            last1 = int'(ga1);
        end
        if (dn1) begin dn1_cnt++; dn1_cyc = cyc; end
        if (re2) begin
            if (rq2.size() == 0) bad("rd2_unexpected");
            else begin a = rq2.pop_front(); chk("rd2_addr", 32'(ad2), 32'(a)); end
        end
        if (we2) begin
            if (wq2.size() == 0) bad("wr2_unexpected");
            else begin
                w = wq2.pop_front();
                chk("wr2_addr", 32'(ga2), 32'(w.addr));
                chk("wr2_data", 32'(wd2), 32'(w.data));
            end
            wr2_cnt++;
            last2 = int'(ga2);
        end
        if (dn2) begin dn2_cnt++; dn2_cyc = cyc; end
        if (tbl_on) begin
            for (int i = 0; i < 7; i++) begin
                if (cyc - tbl_t == tbl[i].off) begin
                    chk("tbl_mem_re", 32'(re1), 32'(tbl[i].mem_re));
                    chk("tbl_gpu_we", 32'(we1), 32'(tbl[i].gpu_we));
                    chk("tbl_busy",   32'(bz1), 32'(tbl[i].busy));
                    chk("tbl_done",   32'(dn1), 32'(tbl[i].done));
                end
            end
        end
    endtask

    // Returns mid-cycle (negedge) of cycle cyc with that cycle's outputs checked.
    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        sample();
    endtask

    task automatic clr1();
        wr1_cnt = 0; dn1_cnt = 0; dn1_cyc = -1; last1 = -1;
        rq1.delete(); wq1.delete();
    endtask

    // Queue the full expected transfer for dut1 and pulse copy_start on this cycle.
    task automatic start1(output int t);
        wr_t w;
        for (int i = 0; i < TOTAL1; i++) begin
            rq1.push_back(16'(i));
            w.addr = 9'(i);
            w.data = mem_word(16'(i));
            wq1.push_back(w);
        end
        t = cyc;
        cs1 = 1'b1;
        step();
        cs1 = 1'b0;
    endtask

    initial begin
        int t;
        int wr_before;
        wr_t w;
        logic [15:0] a;

        rst_n = 1'b0; cs1 = 1'b0; cp1 = 1'b1; cs2 = 1'b0; cp2 = 1'b1;
        clr1();
        wr2_cnt = 0; dn2_cnt = 0; dn2_cyc = -1; last2 = -1;

        // Reset values
        repeat (3) step();
        chk("rst_mem_re",   32'(re1), 32'(0));
        chk("rst_gpu_we",   32'(we1), 32'(0));
        chk("rst_busy",     32'(bz1), 32'(0));
        chk("rst_done",     32'(dn1), 32'(0));
        chk("rst_overrun",  32'(ov1), 32'(0));
        chk("rst_mem_addr", 32'(ad1), 32'(0));
        chk("rst_gpu_addr", 32'(ga1), 32'(0));
        chk("rst_wdata",    32'(wd1), 32'(0));
        chk("rst_mem_addr2", 32'(ad2), 32'h0000FFFE);
        rst_n = 1'b1;

        // Normal copy with copy_start on cycle 10, timing table relative to it
        tbl[0] = '{0,           1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1,           1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{2,           1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{TOTAL1,      1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{TOTAL1 + 1,  1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{TOTAL1 + 2,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{TOTAL1 + 3,  1'b0, 1'b0, 1'b0, 1'b0};
        tbl_t = 10;
        tbl_on = 1'b1;
        while (cyc < 10) step();
        start1(t);
        repeat (399) step();
        tbl_on = 1'b0;
        chk("n_writes",   32'(wr1_cnt), 32'(TOTAL1));
        chk("n_last",     32'(last1), 32'(TOTAL1 - 1));
        chk("n_done_cnt", 32'(dn1_cnt), 32'(1));
        chk("n_done_cyc", 32'(dn1_cyc), 32'(332));
        chk("n_overrun",  32'(ov1), 32'(0));
        chk("n_q_empty",  32'(wq1.size() + rq1.size()), 32'(0));

        // Short vblank: copy low during cycle t+100, so writes stop after address 98
        clr1();
        start1(t);
        while (cyc < t + 100) step();
        cp1 = 1'b0;
        repeat (10) step();
        chk("sv_last_le98", 32'(last1 <= 98), 32'(1));
        chk("sv_last",      32'(last1), 32'(98));
        chk("sv_writes",    32'(wr1_cnt), 32'(99));
        chk("sv_no_done",   32'(dn1_cnt), 32'(0));
        chk("sv_overrun",   32'(ov1), 32'(1));
        chk("sv_busy",      32'(bz1), 32'(0));
        cp1 = 1'b1;
        step();
        clr1();
        start1(t);
        chk("sv_ovr_clear", 32'(ov1), 32'(0));
        repeat (330) step();
        chk("sv2_writes",   32'(wr1_cnt), 32'(TOTAL1));
        chk("sv2_done",     32'(dn1_cnt), 32'(1));
        chk("sv2_overrun",  32'(ov1), 32'(0));

        // Double start: second pulse at t+50 is ignored but flags overrun
        clr1();
        start1(t);
        while (cyc < t + 50) step();
        cs1 = 1'b1;
        step();
        cs1 = 1'b0;
        chk("ds_ovr_set",  32'(ov1), 32'(1));
        repeat (300) step();
        chk("ds_writes",   32'(wr1_cnt), 32'(TOTAL1));
        chk("ds_done",     32'(dn1_cnt), 32'(1));
        chk("ds_done_cyc", 32'(dn1_cyc), 32'(t + TOTAL1 + 2));
        chk("ds_overrun",  32'(ov1), 32'(1));
        chk("ds_q_empty",  32'(wq1.size() + rq1.size()), 32'(0));

        // copy_start during DONE is ignored without overrun
        clr1();
        start1(t);
        chk("dn_ovr_clear", 32'(ov1), 32'(0));
        while (cyc < t + TOTAL1 + 2) step();
        chk("dn_in_done", 32'(dn1), 32'(1));
        cs1 = 1'b1;
        step();
        cs1 = 1'b0;
        chk("dn_ignored_busy", 32'(bz1), 32'(0));
        chk("dn_ignored_ovr",  32'(ov1), 32'(0));
        repeat (5) step();
        chk("dn_done_cnt", 32'(dn1_cnt), 32'(1));
        chk("dn_writes",   32'(wr1_cnt), 32'(TOTAL1));

        // Async reset between edges mid-READ
        clr1();
        start1(t);
        while (cyc < t + 50) step();
        #1 rst_n = 1'b0;
        #1;
        chk("ar_busy",   32'(bz1), 32'(0));
        chk("ar_mem_re", 32'(re1), 32'(0));
        chk("ar_gpu_we", 32'(we1), 32'(0));
        rq1.delete();
        wq1.delete();
        wr_before = wr1_cnt;
        chk("ar_writes_before", 32'(wr_before), 32'(49));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("ar_no_writes", 32'(wr1_cnt), 32'(wr_before));
        chk("ar_idle",      32'(bz1), 32'(0));

        // Variant: 12 words from FFFE, address wraps through 0000
        for (int i = 0; i < TOTAL2; i++) begin
            a = 16'hFFFE + 16'(i);
            rq2.push_back(a);
            w.addr = 9'(i);
            w.data = mem_word(a);
            wq2.push_back(w);
        end
        t = cyc;
        cs2 = 1'b1;
        step();
        cs2 = 1'b0;
        repeat (20) step();
        chk("v_writes",   32'(wr2_cnt), 32'(TOTAL2));
        chk("v_last",     32'(last2), 32'(TOTAL2 - 1));
        chk("v_done_cnt", 32'(dn2_cnt), 32'(1));
        chk("v_done_cyc", 32'(dn2_cyc), 32'(t + TOTAL2 + 2));
        chk("v_q_empty",  32'(wq2.size() + rq2.size()), 32'(0));
        chk("v_overrun",  32'(ov2), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
